// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multi-cycle control path: ALU ops, opcodes, mux selects, states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_control_unit_pkg;

   // ALU control encodings shared with the ALU decoder
   localparam logic [2:0] ALUOP_AND   = 3'b000;
   localparam logic [2:0] ALUOP_OR    = 3'b001;
   localparam logic [2:0] ALUOP_ADD   = 3'b010;
   localparam logic [2:0] ALUOP_RTYPE = 3'b100;
   localparam logic [2:0] ALUOP_SUB   = 3'b110;
   localparam logic [2:0] ALUOP_LESS  = 3'b111;

   // Opcode field values
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b000010;
   localparam logic [5:0] OP_SUBI  = 6'b000011;
   localparam logic [5:0] OP_ANDI  = 6'b000100;
   localparam logic [5:0] OP_ORI   = 6'b000101;
   localparam logic [5:0] OP_SLTI  = 6'b000110;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_MOVE  = 6'b100000;
   localparam logic [5:0] OP_BEQ   = 6'b100011;
   localparam logic [5:0] OP_BNE   = 6'b100111;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JAL   = 6'b111001;

   // PC source select
   localparam logic [1:0] PCSRC_PC4    = 2'b00;
   localparam logic [1:0] PCSRC_BRANCH = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // ALU B operand select
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_ZERO = 2'b11;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_BRANCH = 3'd5,
      ST_JUMP   = 3'd6,
      ST_TRAP   = 3'd7
   } state_t;

   // All datapath controls driven by the FSM, bundled so reset gating is one mux
   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       link;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       trap;
   } ctrl_t;

   // State entered from DECODE for a given opcode; unknown opcodes trap
   function automatic state_t dispatch(input logic [5:0] op);
      state_t nxt;
      case (op)
         OP_RTYPE, OP_MOVE, OP_ADDI, OP_SUBI, OP_ANDI,
         OP_ORI, OP_SLTI, OP_LW, OP_SW:  nxt = ST_EXEC;
         OP_BEQ, OP_BNE:                 nxt = ST_BRANCH;
         OP_J, OP_JAL:                   nxt = ST_JUMP;
         default:                        nxt = ST_TRAP;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mc_control_unit_mem_wait_timer.sv
// Counts consecutive stalled cycles on the memory port and flags a timeout.
// Latency: expired is combinational on the MEM_TIMEOUT-th stalled cycle.
// Backpressure: none; it only observes mem_ready while the FSM is waiting.
module mc_control_unit_mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic waiting,
   input  logic mem_ready,
   input  logic clear,
   output logic expired
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   logic [CNT_W-1:0] cnt;

   // cnt holds the number of earlier stalled cycles, so the compare is against MEM_TIMEOUT-1;
   // a ready on that same cycle is a completion, not a timeout
   assign expired = waiting && !mem_ready && (cnt == CNT_W'(MEM_TIMEOUT - 1));

   // Stall counter: restarts on every state change, saturates at the timeout point
   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (waiting && !mem_ready && !expired)
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: fetch/decode/exec/mem/wb with memory stall timeout and trap.
// Latency: 3 to 5 cycles per instruction plus one per stalled memory cycle.
// Backpressure: holds mem_read/mem_write until mem_ready; traps after MEM_TIMEOUT stalls.
module mc_control_unit
   import mc_control_unit_pkg::*;
#(
   parameter int OPCODE_W    = 6,
   parameter int ALUOP_W     = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_read,
   output logic                mem_write,
   output logic                iord,
   output logic                ir_write,
   output logic                pc_write,
   output logic [1:0]          pc_src,
   output logic                reg_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                link,
   output logic [1:0]          alu_src_b,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                trap,
   output logic [2:0]          state
);

   state_t state_q, state_d;
   ctrl_t  ctrl_c, ctrl_o;
   logic   waiting, expired;
   logic   is_lw, is_sw, taken;

   assign is_lw   = (opcode == OP_LW);
   assign is_sw   = (opcode == OP_SW);
   assign taken   = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
   assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);

   mc_control_unit_mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .waiting   (waiting),
      .mem_ready (mem_ready),
      .clear     (state_d != state_q),
      .expired   (expired)
   );

   // State register; reset restarts at FETCH, which also clears a sticky trap
   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= ST_FETCH;
      else
         state_q <= state_d;
   end

   // Next-state and control decode from current state and opcode
   always_comb begin
      state_d       = state_q;
      ctrl_c        = '0;
      ctrl_c.alu_op = ALUOP_AND;
      case (state_q)
         ST_FETCH: begin
            ctrl_c.mem_read = 1'b1;
            if (mem_ready) begin
               ctrl_c.ir_write = 1'b1;
               ctrl_c.pc_write = 1'b1;
               ctrl_c.pc_src   = PCSRC_PC4;
               state_d         = ST_DECODE;
            end else if (expired) begin
               state_d = ST_TRAP;
            end
         end
         ST_DECODE: state_d = dispatch(opcode);
         ST_EXEC: begin
            case (opcode)
               OP_RTYPE:              begin ctrl_c.alu_op = ALUOP_RTYPE; ctrl_c.alu_src_b = SRCB_REG;  end
               OP_ADDI, OP_LW, OP_SW: begin ctrl_c.alu_op = ALUOP_ADD;   ctrl_c.alu_src_b = SRCB_IMM;  end
               OP_SUBI:               begin ctrl_c.alu_op = ALUOP_SUB;   ctrl_c.alu_src_b = SRCB_IMM;  end
               OP_ANDI:               begin ctrl_c.alu_op = ALUOP_AND;   ctrl_c.alu_src_b = SRCB_IMM;  end
               OP_ORI:                begin ctrl_c.alu_op = ALUOP_OR;    ctrl_c.alu_src_b = SRCB_IMM;  end
               OP_SLTI:               begin ctrl_c.alu_op = ALUOP_LESS;  ctrl_c.alu_src_b = SRCB_IMM;  end
               OP_MOVE:               begin ctrl_c.alu_op = ALUOP_ADD;   ctrl_c.alu_src_b = SRCB_ZERO; end
               default: ;
            endcase
            state_d = (is_lw || is_sw) ? ST_MEM : ST_WB;
         end
         ST_MEM: begin
            ctrl_c.iord      = 1'b1;
            ctrl_c.mem_read  = is_lw;
            ctrl_c.mem_write = is_sw;
            if (mem_ready)
               state_d = is_lw ? ST_WB : ST_FETCH;
            else if (expired)
               state_d = ST_TRAP;
         end
         ST_WB: begin
            ctrl_c.reg_write  = 1'b1;
            ctrl_c.reg_dst    = (opcode == OP_RTYPE);
            ctrl_c.mem_to_reg = is_lw;
            state_d           = ST_FETCH;
         end
         ST_BRANCH: begin
            ctrl_c.alu_op    = ALUOP_SUB;
            ctrl_c.alu_src_b = SRCB_REG;
            if (taken) begin
               ctrl_c.pc_write = 1'b1;
               ctrl_c.pc_src   = PCSRC_BRANCH;
            end
            state_d = ST_FETCH;
         end
         ST_JUMP: begin
            ctrl_c.pc_write  = 1'b1;
            ctrl_c.pc_src    = PCSRC_JUMP;
            ctrl_c.reg_write = (opcode == OP_JAL);
            ctrl_c.link      = (opcode == OP_JAL);
            state_d          = ST_FETCH;
         end
         ST_TRAP: begin
            ctrl_c.trap   = 1'b1;
            ctrl_c.alu_op = '0;
         end
         default: state_d = ST_TRAP;
      endcase
   end

   // Every output reads zero while reset is held, independent of the clock
   assign ctrl_o     = rst_n ? ctrl_c : '0;
   assign state      = rst_n ? state_q : ST_FETCH;
   assign mem_read   = ctrl_o.mem_read;
   assign mem_write  = ctrl_o.mem_write;
   assign iord       = ctrl_o.iord;
   assign ir_write   = ctrl_o.ir_write;
   assign pc_write   = ctrl_o.pc_write;
   assign pc_src     = ctrl_o.pc_src;
   assign reg_write  = ctrl_o.reg_write;
   assign reg_dst    = ctrl_o.reg_dst;
   assign mem_to_reg = ctrl_o.mem_to_reg;
   assign link       = ctrl_o.link;
   assign alu_src_b  = ctrl_o.alu_src_b;
   assign alu_op     = ctrl_o.alu_op;
   assign trap       = ctrl_o.trap;

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle control FSM for the MIPS-basic core, the successor to the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states. It stalls on a ready/valid-style memory handshake, bounds memory waits with a timeout, and traps on illegal opcodes. It sits between the instruction register (opcode, ALU zero flag) and the shared datapath (PC, IR, register file, ALU, unified memory port).

## Interface
- OPCODE_W, 6, opcode field width
- ALUOP_W, 3, ALU control width; must match the shared ALUop encodings
- MEM_TIMEOUT, 15, max cycles waiting on mem_ready before trapping (≥1)
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- opcode  in  OPCODE_W  IR opcode field; stable from DECODE until next FETCH completes
- zero  in  1  ALU zero flag; sampled in BRANCH
- mem_ready  in  1  memory completed the current read/write this cycle
- mem_read, mem_write  out  1  memory request; held until mem_ready
- iord  out  1  memory address select: 0 = PC, 1 = ALU result
- ir_write  out  1  load IR
- pc_write  out  1  update PC
- pc_src  out  2  00 = PC+4, 01 = branch target, 10 = jump target
- reg_write, reg_dst, mem_to_reg, link  out  1  register-file write controls; link selects $ra / PC+4
- alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = const 0
- alu_op  out  ALUOP_W  ALU operation
- trap  out  1  sticky error: illegal opcode or memory timeout
- state  out  3  current state, for debug and bench

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP, TRAP.
- FETCH: mem_read=1, iord=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00; go to DECODE.
- DECODE: no side effects. Dispatch on opcode:
  - R-type 000000, MOVE 100000, ADDI/SUBI/ANDI/ORI, SLTI, LW, SW → EXEC
  - BEQ 100011, BNE 100111 → BRANCH
  - J 111000, JAL 111001 → JUMP
  - Any other opcode → TRAP
- EXEC: drive ALU controls, then go to MEM for LW/SW, otherwise WB.
  - R-type: alu_op=RTYPE, alu_src_b=00
  - ADDI/LW/SW: alu_op=ADD, alu_src_b=10
  - SUBI: alu_op=SUB, alu_src_b=10
  - ANDI: alu_op=AND, alu_src_b=10
  - ORI: alu_op=OR, alu_src_b=10
  - SLTI: alu_op=LESS, alu_src_b=10
  - MOVE: alu_op=ADD, alu_src_b=11
- MEM: iord=1; mem_read for LW, mem_write for SW.
  - On mem_ready: LW → WB, SW → FETCH.
- WB: reg_write=1; reg_dst=1 for R-type only; mem_to_reg=1 for LW only. Then go to FETCH.
- BRANCH: alu_op=SUB, alu_src_b=00. Then go to FETCH.
  - Taken when (BEQ & zero) | (BNE & ~zero): pc_write=1, pc_src=01.
- JUMP: pc_write=1, pc_src=10. Then go to FETCH.
  - JAL additionally: reg_write=1, link=1.
- Timeout counter, width $clog2(MEM_TIMEOUT+1):
  - Counts cycles in FETCH or MEM while mem_ready=0; clears on every state change.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0 → TRAP.
  - mem_ready in the same cycle the counter hits MEM_TIMEOUT counts as a completion, not a timeout.
- TRAP: trap=1; every other control output is 0; stays in TRAP until reset.
- Outputs not listed for a state are 0. alu_op defaults to AND.

## Timing
- Outputs are Moore-style, decoded from the state register plus opcode, except two gated by mem_ready in the same cycle:
  - ir_write and pc_write in FETCH
  - the MEM → WB/FETCH transition
- Reset while rst_n=0 at a clock edge:
  - state ← FETCH, counter ← 0, trap ← 0.
  - All outputs are forced to 0 combinationally while rst_n is low.
  - The first mem_read is issued in the first cycle with rst_n high.
- Reset mid-instruction aborts the instruction; no partial write-back occurs.
- Cycle counts with zero wait states, FETCH included:
  - LW: 5
  - R-type, I-type ALU, SW: 4
  - Branch, jump: 3
  - Each cycle of mem_ready=0 adds one cycle.

## Structure
- mips_defines.vh holds:
  - ALUop_* encodings
  - opcode localparams, moved out of the decoder so both units share them
  - state encodings
  - pc_src and alu_src_b encodings
- One natural sub-module: mem_wait_timer (counter plus timeout compare, parametrised by MEM_TIMEOUT). Everything else stays in mc_control_unit.

## Test plan
- ADDI (000010), mem_ready tied 1 → states FETCH, DECODE, EXEC, WB, FETCH; in EXEC alu_op=ADD, alu_src_b=10; in WB reg_write=1, reg_dst=0.
- LW with mem_ready low 3 cycles in MEM → MEM lasts 4 cycles with mem_read=1, iord=1 throughout; WB has mem_to_reg=1; total 8 cycles.
- BEQ with zero=1, then BNE with zero=1 → first: pc_write=1, pc_src=01 in BRANCH; second: pc_write=0.
- JAL (111001) → JUMP asserts pc_write=1, pc_src=10, reg_write=1, link=1, then FETCH.
- Opcode 111111, and separately mem_ready held 0 for 15 FETCH cycles → trap=1, state=TRAP, all other outputs 0. rst_n low for one edge → state=FETCH, trap=0.
- mem_ready arrives on exactly the 15th wait cycle → normal completion, no trap.
